// File: rtl/line_buffer_3x3_if.sv
// rtl/line_buffer_3x3_if.sv - pixel stream in, vertically aligned pixel triple out

interface line_buffer_3x3_if;
   logic       done_i;
   logic [7:0] data_i;
   logic [7:0] S1_o;
   logic [7:0] S2_o;
   logic [7:0] S3_o;
   logic       done_o;
   logic       progress_done_o;

   // Producer side: drives pixels, observes the aligned column triple
   modport master (
      output done_i,
      output data_i,
      input  S1_o,
      input  S2_o,
      input  S3_o,
      input  done_o,
      input  progress_done_o
   );

   // Line buffer side
   modport slave (
      input  done_i,
      input  data_i,
      output S1_o,
      output S2_o,
      output S3_o,
      output done_o,
      output progress_done_o
   );
endinterface

// File: rtl/line_buffer_3x3.sv
// rtl/line_buffer_3x3.sv - 3-row streaming line buffer feeding the 3x3 window buffer

module line_buffer_3x3 #(
   parameter int COLS = 5,
   parameter int ROWS = 5
) (
   input  logic               clk,
   input  logic               rst,
   line_buffer_3x3_if.slave   px
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_FILL  = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_OUT0  = ROW_W'(2);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [1:0]       state;

   // lb1 holds row r-1, lb0 holds row r-2; never cleared because rows 0-1
   // of every frame rewrite them before the first valid output.
   logic [7:0] lb0 [COLS];
   logic [7:0] lb1 [COLS];

   logic accept;
   logic col_wrap;
   logic fill_end;
   logic frame_end;

   assign accept    = px.done_i;
   assign col_wrap  = (col == COL_LAST);
   assign fill_end  = col_wrap && (row == ROW_FILL);
   assign frame_end = col_wrap && (row == ROW_LAST);

   // Raster position of the next pixel; wraps straight into the next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_wrap) begin
            col <= '0;
            if (frame_end)
               row <= '0;
            else
               row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Frame phase tracking: idle until the first pixel, fill rows 0-1, then stream
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (accept) begin
         case (state)
            ST_IDLE:   state <= (frame_end) ? ST_IDLE : ST_FILL;
            ST_FILL:   if (fill_end)  state <= ST_STREAM;
            ST_STREAM: if (frame_end) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Shift the column through the two line memories on each accepted pixel
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         lb0[col] <= lb1[col];
         lb1[col] <= px.data_i;
      end
   end

   // Registered column triple and strobes; data holds during input gaps
   always_ff @(posedge clk) begin
      if (rst) begin
         px.S1_o            <= '0;
         px.S2_o            <= '0;
         px.S3_o            <= '0;
         px.done_o          <= 1'b0;
         px.progress_done_o <= 1'b0;
      end else if (accept) begin
         px.S1_o            <= lb0[col];
         px.S2_o            <= lb1[col];
         px.S3_o            <= px.data_i;
         px.done_o          <= (row >= ROW_OUT0);
         px.progress_done_o <= frame_end;
      end else begin
         px.done_o          <= 1'b0;
         px.progress_done_o <= 1'b0;
      end
   end

endmodule
